// File: rtl/sw_led_pkg.sv
// sw_led_pkg: mode encoding, default timing constants and mode-step helper for the LED sequencer
package sw_led_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;
    localparam int DEFAULT_TICK_CYCLES     = 3000000;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_PASS  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: synchronizes a bouncing switch, debounces it and flags rising edges of the clean level
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (sync1 != o_level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // two-flop synchronizer, disagreement run counter, accepted level and one-cycle press on a 0->1 accept
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_press <= 1'b0;
        end else begin
            sync0   <= i_sw;
            sync1   <= sync0;
            cnt     <= (sync1 == o_level || done) ? '0 : cnt + CW'(1);
            o_level <= done ? sync1 : o_level;
            o_press <= done && sync1;
        end
    end

endmodule

// File: rtl/sw_led_sequencer.sv
// sw_led_sequencer: press-driven mode FSM driving four LEDs with off/pass-through/blink/chase patterns
module sw_led_sequencer
    import sw_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sw,
    output logic       o_led,
    output logic       o_led1,
    output logic       o_led2,
    output logic       o_led3,
    output logic [1:0] o_mode
);

    localparam int TW = $clog2(TICK_CYCLES);

    logic          level;
    logic          press;
    logic          tick;
    mode_t         mode;
    mode_t         mode_nx;
    logic [3:0]    led;
    logic [3:0]    led_nx;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nx;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sw   (i_sw),
        .o_level(level),
        .o_press(press)
    );

    assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

    // mode, LED pattern and tick counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode     <= MODE_OFF;
            led      <= 4'h0;
            tick_cnt <= '0;
        end else begin
            mode     <= mode_nx;
            led      <= led_nx;
            tick_cnt <= tick_nx;
        end
    end

    // a press advances the mode and restarts both the tick period and the pattern; otherwise ticks step the pattern
    always_comb begin
        mode_nx = press ? next_mode(mode) : mode;
        tick_nx = (press || tick) ? '0 : tick_cnt + TW'(1);
        led_nx  = led;
        if (press)
            led_nx = (mode_nx == MODE_OFF)   ? 4'h0 :
                     (mode_nx == MODE_PASS)  ? {3'b000, level} :
                     (mode_nx == MODE_BLINK) ? 4'hf : 4'h1;
        else if (mode == MODE_PASS)
            led_nx = {3'b000, level};
        else if (tick)
            led_nx = (mode == MODE_BLINK) ? ~led :
                     (mode == MODE_CHASE) ? {led[2:0], led[3]} : 4'h0;
    end

    assign o_led  = led[0];
    assign o_led1 = led[1];
    assign o_led2 = led[2];
    assign o_led3 = led[3];
    assign o_mode = mode;

endmodule

// File: tb/tb_sw_led_sequencer.sv
// tb_sw_led_sequencer: random switch stimulus against a history-based model, checked by an output-event scoreboard
module tb_sw_led_sequencer;

    localparam int D = 4;
    localparam int T = 8;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b1;
    logic       led0, led1, led2, led3;
    logic [1:0] mode;

    ev_t        sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    bit         sw_q[$];
    bit         sync_q[$];
    bit         m_db    = 1'b0;
    bit         m_press = 1'b0;
    int         m_mode  = 0;
    int         m_entry = 0;
    logic [3:0] m_led   = 4'h0;
    logic [5:0] exp_prev = 'x;

    sw_led_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES    (T)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_sw   (sw),
        .o_led  (led0),
        .o_led1 (led1),
        .o_led2 (led2),
        .o_led3 (led3),
        .o_mode (mode)
    );

    always #5 clk = ~clk;

    // LED image for a mode, k cycles after it was entered
    function automatic logic [3:0] pattern(input int md, input int k, input bit dbo);
        return md == 0 ? 4'h0 :
               md == 1 ? {3'b000, dbo} :
               md == 2 ? (((k / T) % 2) != 0 ? 4'h0 : 4'hf) :
               4'(1 << ((k / T) % 4));
    endfunction

    // advance the reference by one clock edge and queue any change in the visible outputs
    task automatic model_step(input bit r, input bit s);
        logic [5:0] ex;
        bit         sync;
        bit         flip;
        bit         db_old;
        if (r) begin
            sw_q.delete();
            sync_q.delete();
            m_db    = 1'b0;
            m_press = 1'b0;
            m_mode  = 0;
            m_entry = cyc;
            m_led   = 4'h0;
        end else begin
            db_old = m_db;
            sync   = (sw_q.size() >= 2) ? sw_q[sw_q.size() - 2] : 1'b0;
            sync_q.push_back(sync);
            sw_q.push_back(s);
            flip = (sync_q.size() >= D);
            for (int i = 0; i < D && flip; i++)
                if (sync_q[sync_q.size() - 1 - i] == m_db) flip = 1'b0;
            if (m_press) begin
                m_mode  = (m_mode + 1) % 4;
                m_entry = cyc;
            end
            m_led = pattern(m_mode, cyc - m_entry, db_old);
            if (flip) m_db = !m_db;
            m_press = flip && m_db;
        end
        ex = {2'(m_mode), m_led};
        if (ex !== exp_prev) begin
            sb.push_back('{cyc, ex});
            exp_prev = ex;
        end
    endtask

    task automatic step(input bit r, input bit s);
        rst = r;
        sw  = s;
        @(posedge clk);
        cyc++;
        model_step(r, s);
        @(negedge clk);
    endtask

    task automatic hold(input bit s, input int n);
        repeat (n) step(1'b0, s);
    endtask

    // monitor: every change of the DUT outputs must match the next queued event, value and cycle
    initial begin
        logic [5:0] prev;
        logic [5:0] cur;
        ev_t        e;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = {mode, led3, led2, led1, led0};
            if (cur !== prev) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.val !== cur) begin
                        n_bad++;
                        $display("FAIL out_event cyc=%0d got=%b required=%b at cyc %0d", cyc, cur, e.val, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        repeat (2) step(1'b1, 1'b1);
        hold(1'b1, 3);
        hold(1'b0, 12);
        hold(1'b1, 20);
        hold(1'b0, 20);
        hold(1'b1, 10);
        hold(1'b0, 40);
        hold(1'b1, 10);
        hold(1'b0, 45);
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        repeat (3) begin
            hold(1'b1, 9);
            hold(1'b0, 30);
        end
        hold(1'b1, 5);
        step(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 12);
        for (int i = 0; i < 120; i++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = (i % 3 == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            for (int j = 0; j < len; j++)
                step($urandom_range(0, 150) == 0, lvl);
        end
        hold(1'b0, 20);
        while (sb.size() != 0) begin
            ev_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event required=%b at cyc %0d", e.val, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_led_sequencer.md
SW_LED_SEQUENCER -- requirements
Module: sw_led_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, SHALL set the consecutive stable cycles needed to accept a new switch level (10 ms at 12 MHz).
REQ-002 Parameter TICK_CYCLES, default 3000000, SHALL set the pattern step period in clocks (0.25 s at 12 MHz).
REQ-003 i_clk  in  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_sw  in  1  raw asynchronous, bouncing switch.
REQ-006 o_led  out  1  LED 0.
REQ-007 o_led1  out  1  LED 1.
REQ-008 o_led2  out  1  LED 2.
REQ-009 o_led3  out  1  LED 3.
REQ-010 o_mode  out  2  current mode: 0 OFF, 1 PASS, 2 BLINK, 3 CHASE.

Function
REQ-011 i_sw SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear the debounce counter.
REQ-013 A 0->1 transition of the debounced level SHALL produce a one-cycle press pulse; 1->0 transitions SHALL produce no pulse.
REQ-014 Mode FSM SHALL advance OFF->PASS->BLINK->CHASE->OFF, one step per press pulse; no other transitions.
REQ-015 o_mode and all LED outputs SHALL be registered and update on the clock edge after the press pulse cycle.
REQ-016 Tick counter SHALL count 0..TICK_CYCLES-1, pulse tick when at TICK_CYCLES-1, then wrap to 0.
REQ-017 On every mode change the tick counter SHALL clear to 0 and the pattern SHALL restart at its entry value.
REQ-018 Press pulse and tick in the same cycle: press SHALL win; the tick SHALL be discarded.
REQ-019 OFF: all four LEDs 0.
REQ-020 PASS: o_led SHALL equal the debounced level (one-cycle register delay); o_led1..3 SHALL be 0.
REQ-021 BLINK: entry all four LEDs 1; all four SHALL toggle together on each tick.
REQ-022 CHASE: entry {o_led3,o_led2,o_led1,o_led}=0001; the one-hot pattern SHALL rotate toward o_led3 on each tick, 1000 wrapping to 0001.
REQ-023 In CHASE exactly one LED SHALL be 1 at all times.

Reset
REQ-024 While i_reset is high at a clock edge, all LEDs, o_mode, debounced level, synchronizer flops, press pulse, debounce counter and tick counter SHALL be 0 on the following edge.
REQ-025 Reset asserted mid-debounce or mid-pattern SHALL abandon that activity; after release the block SHALL behave as from power-up with mode OFF.
REQ-026 A switch held high through reset release SHALL register as a press after 2+DEBOUNCE_CYCLES cycles, since the debounced level restarts at 0.

Structure
REQ-027 Shared package sw_led_pkg SHALL hold the mode enumeration (2-bit encodings of REQ-010) and the default DEBOUNCE_CYCLES and TICK_CYCLES constants.
REQ-028 Synchronizer, debounce and press-pulse generation SHALL be one sub-module, sw_debounce, with outputs debounced level and press pulse.
REQ-029 Counter widths SHALL be derived from the parameters with $clog2 and SHALL not overflow at any legal parameter value (>=2).

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=8)
REQ-030 Reset for 2 cycles with i_sw=1 -> all LEDs 0 and o_mode=0 on the edge after reset is sampled.
REQ-031 i_sw pulsed high for 3 cycles, then low -> o_mode stays 0; no press pulse.
REQ-032 i_sw held high 20 cycles from OFF -> o_mode=1 and o_led=1 within 2+4+2 cycles of the rise; release -> o_led=0 within 2+4+1 cycles.
REQ-033 Four clean presses -> o_mode steps 1,2,3,0; after the fourth press all LEDs are 0.
REQ-034 In CHASE, LED vector steps 0001,0010,0100,1000,0001 at exactly 8-cycle intervals; in BLINK, 1111/0000 alternate every 8 cycles.
REQ-035 Reset pulsed for 1 cycle mid-CHASE and mid-debounce -> all outputs 0 on the next edge; subsequent clean press yields o_mode=1.
